plant_emulator_q44: RTL and testbench

- Hardware discrete-time plant model that closes the loop around pid_controller.
- Consumes the controller's Q4.4 ctrl_out as actuator input and produces the Q4.4 meas the controller reads.
- Models a first-order lag with optional transport delay and an additive disturbance.
- Sits on the plant side of the ref/meas/ctrl_out interface in loop-level sims and on-chip self-test.

---
 rtl/plant_emulator_q44.sv | 109 ++++++++++
 tb/tb_plant_emulator_q44.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plant_emulator_q44.sv
// Discrete-time first-order lag plant with optional transport delay and an
// additive output disturbance; Q4.4 in, Q4.4 out, one update every DIV clocks.
module plant_emulator_q44 #(
  parameter int DIV   = 4,
  parameter int SHIFT = 2,
  parameter int DELAY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic signed [7:0] u_in,
  input  logic signed [7:0] dist_in,
  output logic signed [7:0] meas,
  output logic              meas_valid,
  output logic              sat_flag,
  output logic        [1:0] state_dbg
);

  // Handshake: meas_valid is a single-cycle pulse with no back-pressure; meas
  // holds its value until the next pulse and is valid whenever meas_valid is high.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam int CW = $clog2(DIV);
  localparam int DL = (DELAY == 0) ? 1 : DELAY;

  state_t            state;
  logic [CW-1:0]     count;
  logic              tick;
  logic signed [7:0] y;
  logic signed [7:0] u_d;
  logic signed [7:0] u_sel;
  logic signed [7:0] dl [DL];

  logic signed [9:0] y10, ud10, dist10, diff, step, calc_sum, pub_sum;

  function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
    if (v > 10'sd127)       return 8'sd127;
    else if (v < -10'sd128) return -8'sd128;
    else                    return v[7:0];
  endfunction

  function automatic logic ovf(input logic signed [9:0] v);
    return (v > 10'sd127) || (v < -10'sd128);
  endfunction

  assign tick      = en && (count == CW'(DIV - 1));
  assign state_dbg = state;

  // With no transport delay the current sample feeds the lag directly.
  assign u_sel = (DELAY == 0) ? u_in : dl[DL-1];

  assign y10      = $signed({{2{y[7]}}, y});
  assign ud10     = $signed({{2{u_d[7]}}, u_d});
  assign dist10   = $signed({{2{dist_in[7]}}, dist_in});
  assign diff     = ud10 - y10;
  assign step     = diff >>> SHIFT;
  assign calc_sum = y10 + step;
  assign pub_sum  = y10 + dist10;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      y          <= '0;
      u_d        <= '0;
      meas       <= '0;
      meas_valid <= 1'b0;
      sat_flag   <= 1'b0;
      for (int i = 0; i < DL; i++) dl[i] <= '0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            u_d <= u_sel;
            for (int i = DL - 1; i > 0; i--) dl[i] <= dl[i-1];
            dl[0] <= u_in;
            state <= CALC;
          end
        end
        CALC: begin
          y        <= sat8(calc_sum);
          sat_flag <= sat_flag | ovf(calc_sum);
          state    <= PUBLISH;
        end
        PUBLISH: begin
          meas       <= sat8(pub_sum);
          meas_valid <= 1'b1;
          sat_flag   <= sat_flag | ovf(pub_sum);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plant_emulator_q44.sv
// Bench for plant_emulator_q44: three parameterisations share one stimulus,
// checked by directed vector tables and an arithmetic reference model.
module tb_plant_emulator_q44;

  logic              clk;
  logic              rst;
  logic              en;
  logic signed [7:0] u_in;
  logic signed [7:0] dist_in;

  logic signed [7:0] meas_w [3];
  logic              mv_w   [3];
  logic              sat_w  [3];
  logic        [1:0] st_w   [3];

  int divs   [3] = '{4, 4, 3};
  int shifts [3] = '{2, 2, 0};
  int delays [3] = '{0, 2, 0};

  plant_emulator_q44 #(.DIV(4), .SHIFT(2), .DELAY(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .u_in(u_in), .dist_in(dist_in),
    .meas(meas_w[0]), .meas_valid(mv_w[0]), .sat_flag(sat_w[0]), .state_dbg(st_w[0]));
  plant_emulator_q44 #(.DIV(4), .SHIFT(2), .DELAY(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .u_in(u_in), .dist_in(dist_in),
    .meas(meas_w[1]), .meas_valid(mv_w[1]), .sat_flag(sat_w[1]), .state_dbg(st_w[1]));
  plant_emulator_q44 #(.DIV(3), .SHIFT(0), .DELAY(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .u_in(u_in), .dist_in(dist_in),
    .meas(meas_w[2]), .meas_valid(mv_w[2]), .sat_flag(sat_w[2]), .state_dbg(st_w[2]));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];

  int  m_cnt [3];
  int  m_y   [3];
  bit  m_sat [3];
  int  m_pub [3];
  int  m_nt  [3];
  bit  m_due [3];
  int  ulog  [3][64];
  int  rel_cyc;

  int  cap_n [3];
  int  cap_m [3][64];
  int  cap_s [3][64];
  int  cap_t [3][64];

  typedef struct {
    int phase;
    int inst;
    int idx;
    int meas;
    int sat;
  } vec_t;
  vec_t tbl [64];
  int   ntbl = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int ph, input int inst, input int idx, input int m, input int s);
    tbl[ntbl] = '{ph, inst, idx, m, s};
    ntbl++;
  endtask

  function automatic int fl_div(input int d, input int s);
    int p;
    p = 1 << s;
    if (d >= 0) return d / p;
    return -((-d + p - 1) / p);
  endfunction

  function automatic int clamp(input int v, output bit o);
    o = 1'b0;
    if (v > 127)  begin o = 1'b1; return 127;  end
    if (v < -128) begin o = 1'b1; return -128; end
    return v;
  endfunction

  task automatic push_exp(input int i, input logic [7:0] v);
    case (i)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int i, output logic [7:0] v);
    v = 8'h00;
    case (i)
      0: if (exp_q0.size() > 0) v = exp_q0.pop_front();
      1: if (exp_q1.size() > 0) v = exp_q1.pop_front();
      default: if (exp_q2.size() > 0) v = exp_q2.pop_front();
    endcase
  endtask

  // Reference model: a tick every DIV enabled clocks; the update it starts is
  // published two clocks later using whatever disturbance is present then.
  task automatic model_loop();
    int ud, v;
    bit o;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        rel_cyc = 0;
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
        for (int i = 0; i < 3; i++) begin
          m_cnt[i] = 0; m_y[i] = 0; m_sat[i] = 0;
          m_pub[i] = 0; m_nt[i] = 0; m_due[i] = 0;
        end
      end else begin
        rel_cyc++;
        for (int i = 0; i < 3; i++) begin
          m_due[i] = 0;
          if (m_pub[i] > 0) begin
            m_pub[i]--;
            if (m_pub[i] == 0) begin
              v = clamp(m_y[i] + int'(dist_in), o);
              m_sat[i] = m_sat[i] | o;
              push_exp(i, 8'(v));
              m_due[i] = 1;
            end
          end
          if (en) begin
            if (m_cnt[i] % divs[i] == divs[i] - 1) begin
              ulog[i][m_nt[i] % 64] = int'(u_in);
              ud = (m_nt[i] >= delays[i]) ? ulog[i][(m_nt[i] - delays[i]) % 64] : 0;
              m_nt[i]++;
              m_y[i] = clamp(m_y[i] + fl_div(ud - m_y[i], shifts[i]), o);
              m_sat[i] = m_sat[i] | o;
              m_pub[i] = 2;
            end
            m_cnt[i]++;
          end
        end
      end
    end
  endtask

  task automatic monitor_loop();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (mv_w[i] || m_due[i]) begin
          total++;
          if (mv_w[i] && !m_due[i]) begin
            bad++;
            $display("FAIL sb_unexpected_pulse inst%0d: got meas_valid=1 expected 0 at rel %0d", i, rel_cyc);
          end else if (!mv_w[i] && m_due[i]) begin
            pop_exp(i, e);
            bad++;
            $display("FAIL sb_missing_pulse inst%0d: got meas_valid=0 expected 1 at rel %0d", i, rel_cyc);
          end else begin
            pop_exp(i, e);
            if (meas_w[i] != e || sat_w[i] != m_sat[i]) begin
              bad++;
              $display("FAIL sb_meas inst%0d: got meas=%0d sat=%0d expected meas=%0d sat=%0d",
                       i, meas_w[i], sat_w[i], $signed(e), m_sat[i]);
            end
          end
          if (mv_w[i] && cap_n[i] < 64) begin
            cap_m[i][cap_n[i]] = int'(meas_w[i]);
            cap_s[i][cap_n[i]] = int'(sat_w[i]);
            cap_t[i][cap_n[i]] = rel_cyc;
            cap_n[i]++;
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_clk();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_caps();
    for (int i = 0; i < 3; i++) cap_n[i] = 0;
  endtask

  task automatic reset_release(input logic signed [7:0] u);
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) step_clk();
    u_in    = u;
    dist_in = 8'sd0;
    en      = 1'b1;
    clear_caps();
    rst     = 1'b0;
  endtask

  task automatic wait_pulses(input int i, input int n, input int budget, input string name);
    int k;
    k = 0;
    while (cap_n[i] < n && k < budget) begin
      step_clk();
      k++;
    end
    if (cap_n[i] < n) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got %0d pulses expected %0d", name, cap_n[i], n);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int k;
    k = 0;
    while (st_w[0] != s && k < budget) begin
      step_clk();
      k++;
    end
    if (st_w[0] != s) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got state %0d expected %0d", name, st_w[0], s);
    end
  endtask

  task automatic run_table(input int ph);
    for (int k = 0; k < ntbl; k++) begin
      if (tbl[k].phase == ph) begin
        check($sformatf("vec p%0d inst%0d #%0d meas", ph, tbl[k].inst, tbl[k].idx),
              cap_m[tbl[k].inst][tbl[k].idx], tbl[k].meas);
        check($sformatf("vec p%0d inst%0d #%0d sat", ph, tbl[k].inst, tbl[k].idx),
              cap_s[tbl[k].inst][tbl[k].idx], tbl[k].sat);
      end
    end
  endtask

  // ---------------- test ----------------
  int up_seq [12] = '{8, 14, 18, 21, 23, 25, 26, 27, 28, 29, 29, 29};
  int n0, r0;

  initial begin
    rst = 1'b1; en = 1'b0; u_in = '0; dist_in = '0;
    clear_caps();

    for (int k = 0; k < 12; k++) add_vec(0, 0, k, up_seq[k], 0);
    add_vec(0, 1, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0);
    for (int k = 2; k < 12; k++) add_vec(0, 1, k, up_seq[k-2], 0);
    add_vec(0, 2, 0, 32, 0);
    add_vec(0, 2, 1, 32, 0);
    add_vec(1, 0, 0, 8, 0);
    add_vec(1, 0, 1, 14, 0);
    add_vec(2, 0, 0, -8, 0);
    add_vec(2, 0, 1, -14, 0);
    add_vec(2, 0, 2, -19, 0);
    add_vec(2, 0, 3, -23, 0);
    add_vec(2, 0, 11, -32, 0);
    add_vec(2, 1, 2, -8, 0);
    add_vec(2, 2, 0, -32, 0);
    add_vec(3, 0, 0, 31, 0);
    add_vec(3, 0, 1, 55, 0);
    add_vec(3, 0, 2, 73, 0);
    add_vec(3, 0, 3, 86, 0);
    add_vec(3, 2, 0, 127, 0);
    add_vec(3, 2, 1, 127, 0);

    fork
      model_loop();
      monitor_loop();
    join_none

    repeat (3) step_clk();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset meas inst%0d", i), int'(meas_w[i]), 0);
      check($sformatf("reset valid inst%0d", i), int'(mv_w[i]), 0);
      check($sformatf("reset sat inst%0d", i), int'(sat_w[i]), 0);
      check($sformatf("reset state inst%0d", i), int'(st_w[i]), 0);
    end

    // Step up from reset
    reset_release(8'sd32);
    wait_pulses(0, 12, 80, "step_up");
    wait_pulses(1, 12, 20, "step_up_delay");
    run_table(0);
    check("first pulse clock", cap_t[0][0], 6);
    check("second pulse clock", cap_t[0][1], 10);

    // Disturbance drives output saturation; flag stays sticky afterwards
    n0 = cap_n[0];
    dist_in = 8'sd127;
    wait_pulses(0, n0 + 1, 10, "dist_pulse");
    dist_in = 8'sd0;
    check("dist meas", cap_m[0][n0], 127);
    check("dist sat", cap_s[0][n0], 1);
    wait_pulses(0, n0 + 2, 10, "dist_recover");
    check("recover meas", cap_m[0][n0+1], 29);
    check("recover sat sticky", cap_s[0][n0+1], 1);

    // Reset asserted in CALC aborts the update
    wait_state(2'd1, 10, "find_calc");
    rst = 1'b1;
    #1;
    check("async rst meas", int'(meas_w[0]), 0);
    check("async rst valid", int'(mv_w[0]), 0);
    check("async rst sat", int'(sat_w[0]), 0);
    check("async rst state", int'(st_w[0]), 0);
    reset_release(8'sd32);
    wait_pulses(0, 2, 20, "restart");
    run_table(1);
    check("restart first pulse clock", cap_t[0][0], 6);

    // Enable dropped during PUBLISH: the in-flight pulse completes, count holds
    wait_state(2'd2, 10, "find_publish");
    en = 1'b0;
    n0 = cap_n[0];
    repeat (10) step_clk();
    check("gap pulses", cap_n[0] - n0, 1);
    en = 1'b1;
    r0 = rel_cyc;
    wait_pulses(0, n0 + 2, 12, "resume");
    check("resume latency", cap_t[0][n0+1] - r0, 5);

    // Step down
    reset_release(-8'sd32);
    wait_pulses(0, 12, 80, "step_down");
    run_table(2);

    // Full-scale input with SHIFT=0 must not wrap
    reset_release(8'sd127);
    wait_pulses(0, 4, 40, "full_scale");
    run_table(3);

    // Randomised run against the reference model
    reset_release(8'sd0);
    for (int c = 0; c < 3000; c++) begin
      en   = ($urandom_range(0, 9) != 0);
      u_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) dist_in = 8'($urandom_range(0, 255));
      else                           dist_in = 8'($signed($urandom_range(0, 16)) - 8);
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
      else                             rst = 1'b0;
      step_clk();
    end
    rst = 1'b0;
    en  = 1'b1;
    repeat (10) step_clk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
